// File: rtl/complex_frame_ram.sv
// Per-channel complex frame buffer: sequential stream writes, random-access registered reads.
// Latency: read data, rd_valid and rd_mag appear 1 cycle after rd_en; a write lands at the next edge.
// Backpressure: wr_ready drops once DEPTH samples are written and returns after frame_release; optional COMPLEX_MAG_EN adds |re|+|im|.
module complex_frame_ram #(
    parameter int WIDTH      = 8,
    parameter int NUM_CH     = 4,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [NUM_CH-1:0]            wr_ch_en,
    input  logic [NUM_CH*WIDTH-1:0]      wr_real,
    input  logic [NUM_CH*WIDTH-1:0]      wr_imag,
    output logic [ADDR_WIDTH:0]          wr_count,
    output logic                         frame_full,
    input  logic                         frame_release,
    input  logic                         rd_en,
    input  logic [ADDR_WIDTH-1:0]        rd_addr,
    output logic                         rd_valid,
    output logic [NUM_CH*WIDTH-1:0]      rd_real,
    output logic [NUM_CH*WIDTH-1:0]      rd_imag,
    output logic [NUM_CH*(WIDTH+1)-1:0]  rd_mag
);

    typedef enum logic {S_FILL, S_FULL} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                state;
    logic [ADDR_WIDTH-1:0] wrPtr;
    logic                  wrFire;
    logic                  rdInRange;

    assign wrFire    = wr_valid & wr_ready;
    assign rdInRange = ({1'b0, rd_addr} < FULL_COUNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_FILL;
            wrPtr      <= '0;
            wr_count   <= '0;
            wr_ready   <= 1'b1;
            frame_full <= 1'b0;
        end else begin
            case (state)
                S_FILL: begin
                    if (wrFire) begin
                        if (wrPtr == LAST_ADDR) begin
                            wrPtr      <= '0;
                            wr_count   <= FULL_COUNT;
                            state      <= S_FULL;
                            wr_ready   <= 1'b0;
                            frame_full <= 1'b1;
                        end else begin
                            wrPtr    <= wrPtr + ADDR_WIDTH'(1);
                            wr_count <= wr_count + (ADDR_WIDTH + 1)'(1);
                        end
                    end
                end
                S_FULL: begin
                    // Any write offered alongside release is dropped: wr_ready is still low here.
                    if (frame_release) begin
                        state      <= S_FILL;
                        wr_count   <= '0;
                        wr_ready   <= 1'b1;
                        frame_full <= 1'b0;
                    end
                end
                default: state <= S_FILL;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_valid <= 1'b0;
        else     rd_valid <= rd_en;
    end

`ifdef COMPLEX_MAG_EN
    function automatic logic [WIDTH-1:0] absVal(input logic [WIDTH-1:0] x);
        // The most negative value maps to 2**(WIDTH-1), which still fits unsigned.
        return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
    endfunction
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [WIDTH-1:0] memRe [DEPTH];
        logic [WIDTH-1:0] memIm [DEPTH];
        logic [WIDTH-1:0] rdRe;
        logic [WIDTH-1:0] rdIm;

        always_ff @(posedge clk) begin
            if (wrFire && wr_ch_en[c]) begin
                memRe[wrPtr] <= wr_real[c*WIDTH +: WIDTH];
                memIm[wrPtr] <= wr_imag[c*WIDTH +: WIDTH];
            end
        end

        // Reads sample the array before any same-edge write lands, so they return old contents.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rdRe <= '0;
                rdIm <= '0;
            end else if (rd_en) begin
                if (rdInRange) begin
                    rdRe <= memRe[rd_addr];
                    rdIm <= memIm[rd_addr];
                end else begin
                    rdRe <= '0;
                    rdIm <= '0;
                end
            end
        end

        assign rd_real[c*WIDTH +: WIDTH] = rdRe;
        assign rd_imag[c*WIDTH +: WIDTH] = rdIm;

`ifdef COMPLEX_MAG_EN
        assign rd_mag[c*(WIDTH+1) +: (WIDTH+1)] = {1'b0, absVal(rdRe)} + {1'b0, absVal(rdIm)};
`endif
    end

`ifndef COMPLEX_MAG_EN
    assign rd_mag = '0;
`endif

endmodule
